wb_bram_burst: RTL and testbench



---
 rtl/wb_bram_burst.sv | 132 +++++++++++++
 tb/tb_wb_bram_burst.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bram_burst.sv
// Wishbone B4 block-RAM slave with zero-wait writes, one-wait-state reads and
// registered-feedback incrementing bursts (linear / wrap-4/8/16), ERR on out-of-range.
`timescale 1ns/1ps

module wb_bram_burst #(
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_ADR_WIDTH = 11,
  parameter int ADR_WIDTH     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cyc,
  input  logic                    stb,
  input  logic                    we,
  input  logic [ADR_WIDTH-1:0]    adr,
  input  logic [DATA_WIDTH/8-1:0] sel,
  input  logic [DATA_WIDTH-1:0]   dat_ms,
  input  logic [2:0]              cti,
  input  logic [1:0]              bte,
  output logic [DATA_WIDTH-1:0]   dat_sm,
  output logic                    ack,
  output logic                    err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BO    = $clog2(BYTES);
  localparam int DEPTH = 2 ** MEM_ADR_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_t;

  state_t                   state, state_nxt;
  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [MEM_ADR_WIDTH-1:0] badr;
  logic [MEM_ADR_WIDTH-1:0] wi;
  logic [MEM_ADR_WIDTH-1:0] rd_idx;
  logic                     run_p0;
  logic                     bus_en;
  logic                     req;
  logic                     oor;
  logic                     wr_en;
  logic                     rd_en;
  logic                     unused_adr;

  function automatic logic is_burst(input logic [2:0] c);
    return (c == 3'b001) || (c == 3'b010);
  endfunction

  // Constant bursts repeat the word; wrap modes only advance the low k bits.
  function automatic logic [MEM_ADR_WIDTH-1:0] nxt_adr(
    input logic [MEM_ADR_WIDTH-1:0] a,
    input logic [2:0]               c,
    input logic [1:0]               b
  );
    logic [MEM_ADR_WIDTH-1:0] mask;
    logic [MEM_ADR_WIDTH-1:0] inc;
    inc = a + 1'b1;
    case (b)
      2'b01:   mask = MEM_ADR_WIDTH'(3);
      2'b10:   mask = MEM_ADR_WIDTH'(7);
      2'b11:   mask = MEM_ADR_WIDTH'(15);
      default: mask = '1;
    endcase
    if (c == 3'b001) return a;
    return (a & ~mask) | (inc & mask);
  endfunction

  // ack/err are held off both while rst_n is low and for the first cycle after it rises.
  assign bus_en     = rst_n & run_p0;
  assign req        = cyc & stb;
  assign oor        = req & ((adr >> (MEM_ADR_WIDTH + BO)) != '0);
  assign wi         = adr[MEM_ADR_WIDTH+BO-1:BO];
  assign wr_en      = bus_en & req & we & ~oor;
  assign unused_adr = &{1'b0, adr};

  assign ack = bus_en & req & ~oor & (we | (state == DATA));
  assign err = bus_en & oor;

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    rd_idx    = wi;
    if (!bus_en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req & ~we & ~oor) begin
            rd_en     = 1'b1;
            state_nxt = DATA;
          end
        end
        DATA: begin
          if (req & ~we & ~oor & is_burst(cti)) begin
            rd_en  = 1'b1;
            rd_idx = nxt_adr(badr, cti, bte);
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // stage p0: request -> registered read word / burst address
  always_ff @(posedge clk) begin
    run_p0 <= rst_n;
    if (!rst_n) begin
      state  <= IDLE;
      badr   <= '0;
      dat_sm <= '0;
    end else begin
      state <= state_nxt;
      if (rd_en) begin
        badr   <= rd_idx;
        dat_sm <= mem[rd_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BYTES; i++) begin
        if (sel[i]) mem[wi][8*i +: 8] <= dat_ms[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_bram_burst.sv
// Self-checking bench for wb_bram_burst: directed protocol steps plus randomized
// traffic checked against a word-array memory model and arithmetic burst sequences.
`timescale 1ns/1ps

module tb_wb_bram_burst;

  localparam int AW    = 32;
  localparam int DEPTH = 2048;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0;
  logic [3:0]  sel = '0;
  logic [31:0] dat_ms = '0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic [31:0] dat_sm;
  logic        ack, err;

  logic        cyc64 = 1'b0, stb64 = 1'b0, we64 = 1'b0;
  logic [31:0] adr64 = '0;
  logic [7:0]  sel64 = '0;
  logic [63:0] dat_ms64 = '0;
  logic [2:0]  cti64 = '0;
  logic [1:0]  bte64 = '0;
  logic [63:0] dat_sm64;
  logic        ack64, err64;

  int ntests = 0;
  int nfail  = 0;
  logic [31:0] mem_m [DEPTH];

  wb_bram_burst #(.DATA_WIDTH(32), .MEM_ADR_WIDTH(11), .ADR_WIDTH(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .cyc(cyc), .stb(stb), .we(we), .adr(adr),
    .sel(sel), .dat_ms(dat_ms), .cti(cti), .bte(bte),
    .dat_sm(dat_sm), .ack(ack), .err(err)
  );

  wb_bram_burst #(.DATA_WIDTH(64), .MEM_ADR_WIDTH(11), .ADR_WIDTH(AW)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .cyc(cyc64), .stb(stb64), .we(we64), .adr(adr64),
    .sel(sel64), .dat_ms(dat_ms64), .cti(cti64), .bte(bte64),
    .dat_sm(dat_sm64), .ack(ack64), .err(err64)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    ntests++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    next_cycle();
  endtask

  task automatic wr(input int w, input logic [31:0] d, input logic [3:0] s, input bit chk_on);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; cti = 3'b000;
    adr = AW'(w) << 2; sel = s; dat_ms = d;
    #2;
    if (chk_on) begin
      chk("wr_ack", ack, 1);
      chk("wr_err", err, 0);
    end
    next_cycle();
    for (int i = 0; i < 4; i++) if (s[i]) mem_m[w][8*i +: 8] = d[8*i +: 8];
  endtask

  // kind 000 = classic single read, 001 = constant, 010 = incrementing.
  task automatic burst(input int start, input int n, input logic [2:0] kind, input logic [1:0] b);
    int exp_w [$];
    int len, base;
    for (int j = 0; j < n; j++) begin
      if (kind != 3'b010) exp_w.push_back(start);
      else if (b == 2'b00) exp_w.push_back((start + j) % DEPTH);
      else begin
        len  = 2 << b;
        base = start - (start % len);
        exp_w.push_back(base + ((start % len) + j) % len);
      end
    end
    cyc = 1'b1; stb = 1'b1; we = 1'b0; bte = b; adr = AW'(start) << 2;
    cti = (n == 1) ? ((kind == 3'b000) ? 3'b000 : 3'b111) : kind;
    #2;
    chk("rd_wait_ack", ack, 0);
    chk("rd_wait_err", err, 0);
    next_cycle();
    for (int j = 0; j < n; j++) begin
      cti = (j == n - 1) ? ((kind == 3'b000) ? 3'b000 : 3'b111) : kind;
      adr = AW'(exp_w[j]) << 2;
      #2;
      chk("rd_ack", ack, 1);
      chk("rd_err", err, 0);
      chk("rd_data", dat_sm, mem_m[exp_w[j]]);
      next_cycle();
    end
    bus_idle();
  endtask

  initial begin
    logic [18:0] hi;
    int op, w, n;
    logic [2:0] k;

    // Reset held with a write presented: no ack/err, registers cleared.
    rst_n = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b1;
    adr = 32'h10; sel = 4'hF; dat_ms = 32'h1234_5678;
    #2;
    chk("rst_ack0", ack, 0);
    chk("rst_err0", err, 0);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      chk("rst_ack", ack, 0);
      chk("rst_err", err, 0);
      chk("rst_dat", dat_sm, 0);
    end
    rst_n = 1'b1;
    bus_idle();
    bus_idle();

    for (int i = 0; i < DEPTH; i++)
      wr(i, (i < 8) ? (i * 32'h1111_1111) : $urandom, 4'hF, i < 8);
    bus_idle();

    // Classic write, byte-merge rewrite, back-to-back classic reads.
    wr(4, 32'hDEAD_BEEF, 4'hF, 1'b1);
    wr(4, 32'h0000_AA00, 4'b0010, 1'b1);
    bus_idle();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; cti = 3'b000; adr = 32'h10; #2;
    chk("cl_wait", ack, 0);
    next_cycle(); #1;
    chk("cl_ack", ack, 1);
    chk("cl_merge", dat_sm, 32'hDEAD_AAEF);
    next_cycle();
    adr = 32'h14; #2;
    chk("cl2_wait", ack, 0);
    next_cycle(); #1;
    chk("cl2_ack", ack, 1);
    chk("cl2_data", dat_sm, mem_m[5]);
    next_cycle();
    bus_idle();

    burst(2, 4, 3'b010, 2'b00);
    burst(6, 4, 3'b010, 2'b01);
    burst(3, 3, 3'b001, 2'b00);
    burst(13, 8, 3'b010, 2'b10);
    burst(20, 16, 3'b010, 2'b11);
    burst(2047, 3, 3'b010, 2'b00);

    // Out-of-range write then read: err only, word 0 untouched.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h2000; sel = 4'hF; dat_ms = 32'hBAD0_BAD0; cti = 3'b000; #2;
    chk("oor_wr_err", err, 1);
    chk("oor_wr_ack", ack, 0);
    next_cycle();
    we = 1'b0; #2;
    chk("oor_rd_err", err, 1);
    chk("oor_rd_ack", ack, 0);
    next_cycle(); #1;
    chk("oor_rd_noack", ack, 0);
    next_cycle();
    bus_idle();
    burst(0, 1, 3'b000, 2'b00);

    // Out-of-range beat inside a burst returns the slave to IDLE.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; cti = 3'b010; bte = 2'b00; adr = 32'd10 << 2; #2;
    next_cycle(); #1;
    chk("oorb_ack", ack, 1);
    next_cycle();
    adr = 32'h4000_0000; #2;
    chk("oorb_err", err, 1);
    chk("oorb_ack0", ack, 0);
    next_cycle();
    adr = 32'd11 << 2; #2;
    chk("oorb_rewait", ack, 0);
    next_cycle();
    bus_idle();

    // Master drops stb mid-burst, then resumes with a fresh wait state.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; cti = 3'b010; bte = 2'b00; adr = 32'h0; #2;
    next_cycle(); #1;
    chk("ab_ack1", ack, 1);
    chk("ab_dat1", dat_sm, mem_m[0]);
    next_cycle();
    stb = 1'b0; #2;
    chk("ab_drop", ack, 0);
    next_cycle();
    burst(1, 3, 3'b010, 2'b00);

    // Reset mid-burst, then writes blocked while reset is held.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; cti = 3'b010; bte = 2'b00; adr = 32'd8 << 2; #2;
    next_cycle(); #1;
    chk("mr_ack1", ack, 1);
    next_cycle();
    rst_n = 1'b0; #2;
    chk("mr_ack_rst", ack, 0);
    next_cycle();
    we = 1'b1; sel = 4'hF; dat_ms = 32'hCAFE_F00D;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("mr_wr_ack", ack, 0);
      chk("mr_dat", dat_sm, 0);
      next_cycle();
    end
    rst_n = 1'b1;
    bus_idle();
    bus_idle();
    burst(8, 1, 3'b000, 2'b00);

    // Randomized traffic against the word-array model.
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 3);
      w  = $urandom_range(0, DEPTH - 1);
      case (op)
        0: begin
          wr(w, $urandom, 4'($urandom), 1'b1);
          bus_idle();
        end
        1: begin
          n = $urandom_range(1, 10);
          k = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b010;
          burst(w, n, k, 2'($urandom));
        end
        2: begin
          hi = 19'($urandom_range(1, 19'h7FFFF));
          cyc = 1'b1; stb = 1'b1; we = 1'($urandom); cti = 3'b000;
          adr = {hi, 13'($urandom)}; sel = 4'hF; dat_ms = $urandom; #2;
          chk("rnd_oor_err", err, 1);
          chk("rnd_oor_ack", ack, 0);
          next_cycle();
          bus_idle();
        end
        default: burst(w, 1, 3'b000, 2'b00);
      endcase
    end

    // 64-bit instance: sel 0xF0 touches only the upper half of the word.
    cyc64 = 1'b1; stb64 = 1'b1; we64 = 1'b1; adr64 = 32'h18; sel64 = 8'hFF;
    dat_ms64 = 64'h1111_1111_1111_1111; #2;
    chk("w64_ack", ack64, 1);
    next_cycle();
    sel64 = 8'hF0; dat_ms64 = 64'hAAAA_AAAA_BBBB_BBBB; #2;
    chk("w64_ack2", ack64, 1);
    next_cycle();
    we64 = 1'b0; cti64 = 3'b000; #2;
    chk("r64_wait", ack64, 0);
    next_cycle(); #1;
    chk("r64_ack", ack64, 1);
    chk("r64_data", dat_sm64, 64'hAAAA_AAAA_1111_1111);
    next_cycle();
    cyc64 = 1'b0; stb64 = 1'b0;
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
